// File: rtl/fir_pkg.sv
// Shared FIR definitions: default sizes and the load FSM state encoding.
// Used by the FIR core and its load master.
package fir_pkg;

   localparam int NCOEF_DEF  = 64;
   localparam int ADDR_W_DEF = 14;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      COEF = 2'd1,
      DATA = 2'd2,
      FIN  = 2'd3
   } fir_state_e;

endpackage

// File: rtl/fir_load_reg.sv
// FIR-side output register stage: write strobes, address and data.
// addr/din hold their last value between strobes.
module fir_load_reg
   import fir_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              wr_c,
   input  logic              wr_d,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   output logic              cload,
   output logic              dload,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] din
);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cload <= 1'b0;
         dload <= 1'b0;
         addr  <= '0;
         din   <= '0;
      end else begin
         cload <= wr_c;
         dload <= wr_d;
         if (wr_c || wr_d) begin
            addr <= waddr;
            din  <= wdata;
         end
      end
   end

endmodule

// File: rtl/fir_load_master.sv
// Streams NCOEF coefficients then ndata samples from a valid/ready
// source into the FIR core's coefficient and data write ports.
module fir_load_master
   import fir_pkg::*;
#(
   parameter int NCOEF  = NCOEF_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] ndata,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              cload,
   output logic              dload,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] din,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_COEF = ADDR_W'(NCOEF - 1);
   localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

   fir_state_e        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] nd_q, nd_d;
   logic              xfer;

   // s_ready depends on registered state only
   assign s_ready = (state_q == COEF) || (state_q == DATA);
   assign xfer    = s_valid && s_ready;
   assign busy    = (state_q != IDLE);
   assign done    = (state_q == FIN);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         nd_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         nd_q    <= nd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      nd_d    = nd_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = COEF;
               cnt_d   = '0;
               nd_d    = ndata;
            end
         end
         COEF: begin
            if (xfer) begin
               if (cnt_q == LAST_COEF) begin
                  cnt_d   = '0;
                  state_d = (nd_q != '0) ? DATA : FIN;
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
            if (abort) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         DATA: begin
            // nd_q is nonzero whenever DATA is entered
            if (xfer) begin
               if (cnt_q == nd_q - ONE) begin
                  cnt_d   = '0;
                  state_d = FIN;
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
            if (abort) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   fir_load_reg #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_reg (
      .clk   (clk),
      .rstn  (rstn),
      .wr_c  (xfer && (state_q == COEF)),
      .wr_d  (xfer && (state_q == DATA)),
      .waddr (cnt_q),
      .wdata (s_data),
      .cload (cload),
      .dload (dload),
      .addr  (addr),
      .din   (din)
   );

endmodule

// File: doc/fir_load_master.md
FIR_LOAD_MASTER -- requirements
Module: fir_load_master

Interface
REQ-001 The block SHALL have exactly the following parameters (name, default, meaning):
- NCOEF, 64, number of coefficient words loaded per session.
- ADDR_W, 14, width of the FIR load address.
- DATA_W, 16, width of a loaded word.

REQ-002 The block SHALL have exactly the following ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on posedge.
- rstn, in, 1, reset: asynchronous, active-low.
- start, in, 1, one-cycle request to begin a load session.
- abort, in, 1, synchronous cancel of the current session.
- ndata, in, ADDR_W, number of data samples to load this session.
- s_valid, in, 1, upstream word valid.
- s_data, in, DATA_W, upstream word: NCOEF coefficients, then ndata samples.
- s_ready, out, 1, block accepts an upstream word this cycle.
- cload, out, 1, coefficient write strobe to the FIR core.
- dload, out, 1, data write strobe to the FIR core.
- addr, out, ADDR_W, FIR write address.
- din, out, DATA_W, FIR write data.
- busy, out, 1, session in progress.
- done, out, 1, one-cycle pulse when a session completes normally.

Function
REQ-003 The FSM SHALL have the states IDLE, COEF, DATA and FIN.
REQ-004 In IDLE, start=1 SHALL latch ndata into an internal register and move the FSM to COEF with the word counter at 0.
REQ-005 start SHALL be ignored in every state other than IDLE.
REQ-006 s_ready SHALL be 1 exactly in COEF and DATA, decoded from registered state only, with no combinational path from s_valid.
REQ-007 A transfer SHALL occur on a posedge where s_valid=1 and s_ready=1; s_data SHALL be sampled at that edge.
REQ-008 After a transfer in COEF, in the next cycle cload=1, dload=0, addr=counter value and din=sampled word.
REQ-009 After a transfer in DATA, in the next cycle dload=1, cload=0, addr=counter value and din=sampled word.
REQ-010 Latency from transfer edge to strobe SHALL be exactly 1 cycle; back-to-back transfers SHALL produce back-to-back strobes with consecutive addresses.
REQ-011 In any cycle with no preceding transfer, cload=0 and dload=0, and addr and din SHALL hold their last values.
REQ-012 cload and dload SHALL never both be 1.
REQ-013 The counter SHALL increment per transfer; after the transfer with counter=NCOEF-1 in COEF it SHALL reset to 0.
REQ-014 After that last COEF transfer, the FSM SHALL go to DATA if latched ndata != 0, otherwise to FIN.
REQ-015 The transfer with counter=ndata-1 in DATA SHALL move the FSM to FIN.
REQ-016 Addresses SHALL never wrap within a session.
REQ-017 FIN SHALL last exactly 1 cycle, with done=1 and s_ready=0, then return to IDLE; done therefore coincides with the final strobe.
REQ-018 busy SHALL be 1 in COEF, DATA and FIN, and 0 in IDLE.
REQ-019 abort=1 in COEF or DATA SHALL return the FSM to IDLE at the next edge without asserting done.
REQ-020 A transfer coinciding with abort SHALL still produce its strobe in the next cycle; no further transfers SHALL be accepted.
REQ-021 abort in IDLE or FIN SHALL have no effect.
REQ-022 s_valid deasserted mid-session SHALL stall the session indefinitely with no timeout.

Reset
REQ-023 While rstn=0, the FSM SHALL be IDLE and the counter and latched ndata SHALL be 0.
REQ-024 While rstn=0: cload=0, dload=0, addr=0, din=0, s_ready=0, busy=0, done=0.
REQ-025 Reset asserted mid-session SHALL abandon the session immediately, with no strobe or done issued afterwards.

Structure
REQ-026 The FSM state encoding and the NCOEF, ADDR_W and DATA_W defaults SHALL live in a shared package fir_pkg used by the FIR core and this block.
REQ-027 The FIR-side output register stage (cload, dload, addr, din) SHALL be one sub-module, fir_load_reg; everything else stays in this module.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- Reset, start with ndata=10, s_valid held 1 -> 64 consecutive cload cycles at addr 0..63, then 10 dload cycles at addr 0..9; done once, on the cycle of the addr-9 strobe; 75 cycles of busy.
- ndata=0 -> 64 cload strobes only, no dload; done on the addr-63 strobe.
- s_valid toggling 1,0,1,0 during COEF -> strobes spaced 2 cycles apart, addresses contiguous, din equals the accepted words in order.
- abort asserted at the same edge as coefficient transfer 20 -> cload strobe at addr 20, then IDLE; no done; s_ready=0 the next cycle.
- start pulsed during DATA -> ignored; the session completes with the original ndata.
- rstn pulsed low during DATA -> all outputs 0 asynchronously; a new start afterwards begins again at coefficient addr 0.
